// File: rtl/timer_countdown_ctrl.sv
// Countdown sequencer for the RTC/VGA timer digit registers: holds a BCD hh:mm:ss value,
// decrements it once per TICK_DIV clocks and drives hold/chip_select/estado_alarma.
module timer_countdown_ctrl #(
    parameter int unsigned TICK_DIV    = 100000000,
    parameter int unsigned ALARM_TICKS = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load_en,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
    input  logic [7:0] in_hh,
    input  logic [7:0] in_mm,
    input  logic [7:0] in_ss,
    output logic [7:0] count_hh,
    output logic [7:0] count_mm,
    output logic [7:0] count_ss,
    output logic       hold,
    output logic       chip_select,
    output logic       estado_alarma,
    output logic       load_err
);

    localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned AW = $clog2(ALARM_TICKS + 1);

    typedef enum logic [1:0] {StIdle, StRun, StPause, StAlarm} state_e;

    state_e        state_q, state_d;
    logic [23:0]   count_q, count_d;
    logic [PW-1:0] presc_q, presc_d, presc_inc;
    logic [AW-1:0] alarm_cnt_q, alarm_cnt_d;
    logic          load_err_d;
    logic          tick;
    logic          do_stop, do_start, do_load;
    logic          load_ok;
    logic [23:0]   count_dec;

    // Subtract one second in BCD; caller guarantees the value is nonzero.
    function automatic logic [23:0] bcd_dec(input logic [23:0] v);
        logic [23:0] r;
        logic        borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (borrow) begin
                if (r[4*i+:4] != 4'd0) begin
                    r[4*i+:4] = r[4*i+:4] - 4'd1;
                    borrow    = 1'b0;
                end else begin
                    r[4*i+:4] = (i == 1 || i == 3) ? 4'd5 : 4'd9;
                end
            end
        end
        return r;
    endfunction

    function automatic logic bcd_valid(input logic [7:0] v, input logic [7:0] max);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= max);
    endfunction

    assign do_stop   = stop & ~clear;
    assign do_start  = start & ~clear & ~stop;
    assign do_load   = load_en & ~clear & ~stop & ~start;
    assign load_ok   = bcd_valid(in_hh, 8'h23) && bcd_valid(in_mm, 8'h59) &&
                       bcd_valid(in_ss, 8'h59);
    assign tick      = (presc_q == PW'(TICK_DIV - 1));
    assign presc_inc = tick ? '0 : presc_q + PW'(1);
    assign count_dec = bcd_dec(count_q);

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        presc_d     = presc_q;
        alarm_cnt_d = alarm_cnt_q;
        load_err_d  = 1'b0;
        if (clear) begin
            state_d     = StIdle;
            count_d     = '0;
            presc_d     = '0;
            alarm_cnt_d = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (do_start && count_q != 24'h0) begin
                        state_d = StRun;
                        presc_d = '0;
                    end else if (do_load) begin
                        if (load_ok) count_d = {in_hh, in_mm, in_ss};
                        else         load_err_d = 1'b1;
                    end
                end
                StRun: begin
                    // A stop edge does not advance the prescaler; the partial second resumes.
                    if (do_stop) begin
                        state_d = StPause;
                    end else begin
                        presc_d = presc_inc;
                        if (tick) begin
                            count_d = count_dec;
                            if (count_dec == 24'h0) begin
                                state_d     = StAlarm;
                                alarm_cnt_d = '0;
                            end
                        end
                    end
                end
                StPause: begin
                    if (do_start) state_d = StRun;
                end
                StAlarm: begin
                    if (do_stop) begin
                        state_d     = StIdle;
                        presc_d     = '0;
                        alarm_cnt_d = '0;
                    end else begin
                        presc_d = presc_inc;
                        if (tick) begin
                            if (alarm_cnt_q == AW'(ALARM_TICKS - 1)) begin
                                state_d     = StIdle;
                                alarm_cnt_d = '0;
                            end else begin
                                alarm_cnt_d = alarm_cnt_q + AW'(1);
                            end
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Control outputs are registered from the next state so they line up with the state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= StIdle;
            count_q       <= '0;
            presc_q       <= '0;
            alarm_cnt_q   <= '0;
            hold          <= 1'b1;
            chip_select   <= 1'b0;
            estado_alarma <= 1'b0;
            load_err      <= 1'b0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            presc_q       <= presc_d;
            alarm_cnt_q   <= alarm_cnt_d;
            hold          <= (state_d == StPause) || (state_d == StAlarm);
            chip_select   <= (state_d != StIdle);
            estado_alarma <= (state_d == StAlarm);
            load_err      <= load_err_d;
        end
    end

    assign count_hh = count_q[23:16];
    assign count_mm = count_q[15:8];
    assign count_ss = count_q[7:0];

endmodule

// File: doc/timer_countdown_ctrl.md
Name: timer_countdown_ctrl

Overview:
- Sequencing controller for the countdown-timer digit registers of the RTC/VGA clock design.
- Holds a BCD hh:mm:ss countdown value, loaded from the RTC/user-entry bus, and decrements it once per second.
- Drives the shared hold / chip_select / estado_alarma controls of the timer registers and raises the alarm state at 00:00:00.
- Sits between the RTC interface FSM, the user keypad/switch decoder and the timer registers feeding the VGA text generator.

Parameters:
- TICK_DIV, 100000000, clk cycles per one-second tick (>=2); benches use 4.
- ALARM_TICKS, 10, number of seconds estado_alarma stays asserted before auto-return to IDLE (>=1).

Ports:
- clk, input, 1, system clock; all state updates on rising edge.
- reset, input, 1, system reset; asynchronous, active-high.
- load_en, input, 1, one-cycle pulse; capture in_hh/in_mm/in_ss as new countdown value.
- start, input, 1, one-cycle pulse; start or resume countdown.
- stop, input, 1, one-cycle pulse; pause countdown, or acknowledge alarm.
- clear, input, 1, one-cycle pulse; abort, zero the count, return to IDLE.
- in_hh, input, 8, BCD hours 00-23 from RTC/user bus.
- in_mm, input, 8, BCD minutes 00-59.
- in_ss, input, 8, BCD seconds 00-59.
- count_hh, output, 8, current BCD hours.
- count_mm, output, 8, current BCD minutes.
- count_ss, output, 8, current BCD seconds.
- hold, output, 1, 1 = timer registers keep value; 0 = registers follow selected source.
- chip_select, output, 1, 0 = registers take RTC data; 1 = registers take count_* data.
- estado_alarma, output, 1, alarm active.
- load_err, output, 1, one-cycle pulse; load_en rejected because of invalid BCD.

Behaviour:
- All outputs registered. Reset values:
  - state IDLE; count_* = 8'h00; prescaler = 0; alarm counter = 0.
  - hold=1, chip_select=0, estado_alarma=0, load_err=0.
- Reset asserted mid-countdown or mid-alarm returns to these values immediately; the in-progress countdown is lost.
- States are IDLE, RUN, PAUSE, ALARM. Per-state outputs:
  - IDLE: hold=0, chip_select=0.
  - RUN: hold=0, chip_select=1.
  - PAUSE: hold=1, chip_select=1.
  - ALARM: hold=1, chip_select=1, estado_alarma=1.
- Simultaneous pulses: priority clear > stop > start > load_en. Lower-priority pulses in the same cycle are dropped.
- IDLE, load_en:
  - Valid input: each nibble <=9, hh<=8'h23, mm<=8'h59, ss<=8'h59. count_* update on the next edge.
  - Invalid input: count_* unchanged; load_err pulses high for 1 cycle.
- IDLE, start:
  - count nonzero: go to RUN with prescaler = 0.
  - count = 00:00:00: start ignored, stay IDLE.
- load_en is ignored (no load_err) in RUN, PAUSE and ALARM.
- RUN, prescaler and decrement:
  - Prescaler counts 0..TICK_DIV-1. The cycle it equals TICK_DIV-1 is the tick; it wraps to 0 on that edge.
  - On the tick edge, count_* decrement by one second; the new value is visible the cycle after the tick cycle.
  - BCD borrow: ss units 0 -> 9 with tens-1; ss 00 -> 59 borrows from mm; mm 00 -> 59 borrows from hh; hh decrements in BCD (10 -> 09).
  - First decrement occurs TICK_DIV cycles after entering RUN.
- RUN -> ALARM: the tick that makes count 00:00:00 moves the state to ALARM on the same edge, alarm counter = 0. count_* never wrap below zero.
- RUN, stop: go to PAUSE; prescaler value frozen.
- RUN, clear: go to IDLE; count_* = 0, prescaler = 0.
- PAUSE:
  - start: go to RUN, resuming from the frozen prescaler value (no lost partial second).
  - clear: go to IDLE, zeroing as above.
- ALARM:
  - Prescaler keeps running; alarm counter increments per tick.
  - When ALARM_TICKS ticks have elapsed, go to IDLE automatically.
  - stop or clear: go to IDLE next edge.
  - start is ignored.
  - count_* stay 00:00:00.
- No combinational path from inputs to outputs.

Test Plan (TICK_DIV=4, ALARM_TICKS=2):
- Reset check: assert reset mid-RUN -> all counts 00, hold=1, chip_select=0, estado_alarma=0 before the next clk edge; normal IDLE outputs (hold=0) after reset release.
- Borrow chain: load 01:00:00, start -> after 4 cycles count=00:59:59. Also load 00:10:00 -> 00:09:59, confirming both the mm->hh and units borrow rules.
- Pause/resume: load 00:00:05, start, stop 2 cycles after start, wait 20 cycles (count stays 05), start -> first decrement to 04 exactly 2 cycles later.
- Alarm: load 00:00:02, start -> 00:00:01 at cycle 4, ALARM at cycle 8 with estado_alarma=1 and count 00:00:00 -> auto IDLE after 8 more cycles. Repeat with stop at alarm cycle 1 -> IDLE next edge.
- Load validation: load 00:00:00 then start -> stays IDLE. Load ss=8'h5A or hh=8'h24 -> load_err pulses 1 cycle, count unchanged. load_en during RUN -> ignored, no load_err.
- Priority: clear+stop+start same cycle in RUN -> IDLE, count 00. start+load_en same cycle in IDLE with count 00:00:03 -> RUN, count stays 03.
